// File: rtl/judge_overlay_pkg.sv
// Shared definitions for the judge/overlay blocks: class colour table,
// class-lock FSM encoding and the number of colour-mapped classes.
package judge_overlay_pkg;

  localparam int CLASS_COUNT = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } fsm_state_t;

  localparam logic [23:0] CLASS_COLOUR [CLASS_COUNT] = '{
    24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'hFF8000,
    24'h8000FF, 24'h0080FF, 24'h80FF00, 24'hFF0080
  };

  // Classes beyond the table are drawn white.
  function automatic logic [23:0] class_colour(input logic [3:0] cls);
    if (int'(cls) < CLASS_COUNT) return CLASS_COLOUR[cls];
    return 24'hFFFFFF;
  endfunction

endpackage

// File: rtl/judge_overlay_if.sv
// Video stream into and out of the overlay: source side drives i_*,
// overlay side drives o_*.
interface judge_overlay_if;

  logic [23:0] i_rgb;
  logic        i_hsync;
  logic        i_vsync;
  logic        i_de;
  logic [23:0] o_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;

  modport master (
    output i_rgb, i_hsync, i_vsync, i_de,
    input  o_rgb, o_hsync, o_vsync, o_de
  );

  modport slave (
    input  i_rgb, i_hsync, i_vsync, i_de,
    output o_rgb, o_hsync, o_vsync, o_de
  );

endinterface

// File: rtl/judge_overlay_class_fsm.sv
// Frame-rate class debouncer: a class is shown only after it has been
// reported unchanged for STABLE_FRAMES consecutive frame starts.
module overlay_class_fsm
  import judge_overlay_pkg::*;
#(
  parameter int STABLE_FRAMES = 3
) (
  input  logic       pixelclk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic [3:0] sort,
  output logic [3:0] lock_sort,
  output logic       locked
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

  fsm_state_t state;
  logic [3:0] cand;
  logic [3:0] cnt;

  // NOTE: registers are written with <= so every branch sees pre-edge values.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      lock_sort <= '0;
      locked    <= 1'b0;
    end else if (frame_start) begin
      if (sort != cand) begin
        cand <= sort;
        cnt  <= 4'd1;
        if (STABLE_CNT == 4'd1) begin
          state     <= ST_LOCKED;
          lock_sort <= sort;
          locked    <= 1'b1;
        end else begin
          state  <= ST_COUNT;
          locked <= 1'b0;
        end
      end else begin
        case (state)
          ST_COUNT: begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 >= STABLE_CNT) begin
              state     <= ST_LOCKED;
              lock_sort <= cand;
              locked    <= 1'b1;
            end
          end
          ST_LOCKED: if (cnt != 4'hF) cnt <= cnt + 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/judge_overlay.sv
// Draws a class-coloured bounding box border plus a solid tag square onto
// the video stream, one pixelclk of latency, box captured per frame.
module judge_overlay
  import judge_overlay_pkg::*;
#(
  parameter int THICK         = 2,
  parameter int STABLE_FRAMES = 3,
  parameter int TAG           = 8
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [3:0]       sort,
  input  logic [11:0]      hcount_l,
  input  logic [11:0]      hcount_r,
  input  logic [11:0]      vcount_l,
  input  logic [11:0]      vcount_r,
  judge_overlay_if.slave   vid,
  output logic [3:0]       lock_sort,
  output logic             locked
);

  localparam logic [12:0] THICK13 = 13'(THICK);
  localparam logic [12:0] TAG13   = 13'(TAG);

  logic [11:0] hcnt, vcnt;
  logic [11:0] hl_s, hr_s, vl_s, vr_s;
  logic        de_d, vsync_d;
  logic        frame_start;

  assign frame_start = vid.i_vsync & ~vsync_d;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      de_d    <= 1'b0;
      vsync_d <= 1'b0;
      hl_s    <= '0;
      hr_s    <= '0;
      vl_s    <= '0;
      vr_s    <= '0;
    end else begin
      de_d    <= vid.i_de;
      vsync_d <= vid.i_vsync;
      hcnt    <= vid.i_de ? hcnt + 12'd1 : 12'd0;
      if (vid.i_vsync)            vcnt <= '0;
      else if (de_d && !vid.i_de) vcnt <= vcnt + 12'd1;
      if (frame_start) begin
        hl_s <= hcount_l;
        hr_s <= hcount_r;
        vl_s <= vcount_l;
        vr_s <= vcount_r;
      end
    end
  end

  overlay_class_fsm #(.STABLE_FRAMES(STABLE_FRAMES)) u_fsm (
    .pixelclk    (pixelclk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .sort        (sort),
    .lock_sort   (lock_sort),
    .locked      (locked)
  );

  // One extra bit so hr-THICK style limits never wrap; right/bottom edges
  // are tested as x+THICK > hr instead of x > hr-THICK.
  logic [12:0] hc, vc, hl, hr, vl, vr;
  logic        in_box, border, tag, box_ok, paint;

  assign hc = {1'b0, hcnt};
  assign vc = {1'b0, vcnt};
  assign hl = {1'b0, hl_s};
  assign hr = {1'b0, hr_s};
  assign vl = {1'b0, vl_s};
  assign vr = {1'b0, vr_s};

  assign in_box = vid.i_de && (hc >= hl) && (hc <= hr) && (vc >= vl) && (vc <= vr);
  assign border = (hc < hl + THICK13) || (hc + THICK13 > hr) ||
                  (vc < vl + THICK13) || (vc + THICK13 > vr);
  assign tag    = (hc < hl + TAG13) && (vc < vl + TAG13);
  assign box_ok = (hl_s < hr_s) && (vl_s < vr_s);
  assign paint  = en && (lock_sort != 4'd0) && box_ok && in_box && (border || tag);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vid.o_rgb   <= '0;
      vid.o_hsync <= 1'b0;
      vid.o_vsync <= 1'b0;
      vid.o_de    <= 1'b0;
    end else begin
      vid.o_hsync <= vid.i_hsync;
      vid.o_vsync <= vid.i_vsync;
      vid.o_de    <= vid.i_de;
      if (!vid.i_de)  vid.o_rgb <= '0;
      else if (paint) vid.o_rgb <= class_colour(lock_sort);
      else            vid.o_rgb <= vid.i_rgb;
    end
  end

endmodule

// File: tb/tb_judge_overlay.sv
// Directed bench for judge_overlay: class locking, border/tag drawing,
// per-frame box capture, degenerate boxes, bypass and asynchronous reset.
module tb_judge_overlay;

  localparam int W = 310;
  localparam logic [23:0] C2 = 24'h00FF00;
  localparam logic [23:0] C3 = 24'h0000FF;

  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        en       = 1'b1;
  logic [3:0]  sort     = 4'd0;
  logic [11:0] hl = '0, hr = '0, vl = '0, vr = '0;
  logic [3:0]  lock_sort;
  logic        locked;

  judge_overlay_if vid();

  judge_overlay #(.THICK(2), .STABLE_FRAMES(3), .TAG(8)) dut (
    .pixelclk  (pixelclk),
    .reset_n   (reset_n),
    .en        (en),
    .sort      (sort),
    .hcount_l  (hl),
    .hcount_r  (hr),
    .vcount_l  (vl),
    .vcount_r  (vr),
    .vid       (vid),
    .lock_sort (lock_sort),
    .locked    (locked)
  );

  always #5 pixelclk = ~pixelclk;

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          cur_line = 0;
  logic [23:0] out_rgb [W];

  function automatic logic [23:0] pat(input int x, input int y);
    return {y[7:0], 4'h5, x[11:0]};
  endfunction

  task automatic drive(input logic [23:0] rgb, input logic de, input logic hs, input logic vs);
    @(negedge pixelclk);
    vid.i_rgb   = rgb;
    vid.i_de    = de;
    vid.i_hsync = hs;
    vid.i_vsync = vs;
  endtask

  task automatic new_frame(input logic [3:0] s);
    sort = s;
    repeat (3) drive(24'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(24'h0, 1'b0, 1'b0, 1'b0);
    cur_line = 0;
  endtask

  task automatic skip_to(input int y);
    while (cur_line < y) begin
      drive(24'h0, 1'b1, 1'b0, 1'b0);
      drive(24'h0, 1'b0, 1'b1, 1'b0);
      cur_line++;
    end
  endtask

  // Full active line; optionally pulses reset asynchronously at pixel rst_at.
  task automatic full_line(input int rst_at);
    for (int x = 0; x < W; x++) begin
      drive(pat(x, cur_line), 1'b1, 1'b0, 1'b0);
      if (x == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({vid.o_rgb, vid.o_hsync, vid.o_vsync, vid.o_de, lock_sort, locked} !== 33'h0) begin
          n_err++;
          $display("FAIL async_reset_outputs: rgb=%h hs=%b vs=%b de=%b lock=%0d locked=%b want all 0",
                   vid.o_rgb, vid.o_hsync, vid.o_vsync, vid.o_de, lock_sort, locked);
        end
        #1 reset_n = 1'b1;
      end
      @(posedge pixelclk);
      #1 out_rgb[x] = vid.o_rgb;
    end
    drive(24'h0, 1'b0, 1'b1, 1'b0);
    @(posedge pixelclk);
    #1;
    n_cmp++;
    if ({vid.o_de, vid.o_hsync, vid.o_vsync, vid.o_rgb} !== {1'b0, 1'b1, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL blank_after_line%0d: de=%b hs=%b vs=%b rgb=%h want de=0 hs=1 vs=0 rgb=0",
               cur_line, vid.o_de, vid.o_hsync, vid.o_vsync, vid.o_rgb);
    end
    drive(24'h0, 1'b0, 1'b1, 1'b0);
    cur_line++;
  endtask

  task automatic test_reset();
    vid.i_rgb = 24'h123456; vid.i_de = 1'b1; vid.i_hsync = 1'b1; vid.i_vsync = 1'b1;
    repeat (3) @(posedge pixelclk);
    #1;
    n_cmp++;
    if ({vid.o_rgb, vid.o_hsync, vid.o_vsync, vid.o_de} !== 27'h0) begin
      n_err++;
      $display("FAIL reset_video: rgb=%h hs=%b vs=%b de=%b want all 0",
               vid.o_rgb, vid.o_hsync, vid.o_vsync, vid.o_de);
    end
    n_cmp++;
    if ({lock_sort, locked} !== 5'h0) begin
      n_err++;
      $display("FAIL reset_lock: lock_sort=%0d locked=%b want 0/0", lock_sort, locked);
    end
    @(negedge pixelclk);
    reset_n = 1'b1;
    repeat (3) drive(24'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_lock_sequence();
    logic [3:0] seq      [5] = '{4'd3, 4'd3, 4'd5, 4'd5, 4'd5};
    logic [3:0] exp_lock [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
    logic       exp_lkd  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      new_frame(seq[i]);
      n_cmp++;
      if ({lock_sort, locked} !== {exp_lock[i], exp_lkd[i]}) begin
        n_err++;
        $display("FAIL lock_seq_frame%0d: lock_sort=%0d locked=%b want %0d/%b",
                 i + 1, lock_sort, locked, exp_lock[i], exp_lkd[i]);
      end
    end
  endtask

  task automatic test_border();
    logic [3:0] exp_lock [3] = '{4'd5, 4'd5, 4'd3};
    logic       exp_lkd  [3] = '{1'b0, 1'b0, 1'b1};
    int         ys [6]       = '{50, 52, 58, 100, 200, 201};
    int         xs [6][4]    = '{'{99, 100, 300, 301}, '{102, 107, 108, 299},
                                 '{101, 102, 298, 300}, '{99, 100, 150, 301},
                                 '{100, 150, 300, 301}, '{99, 100, 150, 300}};
    logic [3:0] is_c3 [6]    = '{4'b0110, 4'b1011, 4'b1001, 4'b0010, 4'b0111, 4'b0000};
    logic [23:0] want;
    hl = 12'd100; hr = 12'd300; vl = 12'd50; vr = 12'd200;
    for (int i = 0; i < 3; i++) begin
      new_frame(4'd3);
      n_cmp++;
      if ({lock_sort, locked} !== {exp_lock[i], exp_lkd[i]}) begin
        n_err++;
        $display("FAIL relock3_frame%0d: lock_sort=%0d locked=%b want %0d/%b",
                 i + 1, lock_sort, locked, exp_lock[i], exp_lkd[i]);
      end
    end
    new_frame(4'd3);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL frame4_locked: locked=%b want 1", locked);
    end
    for (int l = 0; l < 6; l++) begin
      skip_to(ys[l]);
      full_line(-1);
      for (int k = 0; k < 4; k++) begin
        want = is_c3[l][k] ? C3 : pat(xs[l][k], ys[l]);
        n_cmp++;
        if (out_rgb[xs[l][k]] !== want) begin
          n_err++;
          $display("FAIL border_px(%0d,%0d): got %h want %h", xs[l][k], ys[l], out_rgb[xs[l][k]], want);
        end
      end
    end
  endtask

  task automatic test_box_change();
    new_frame(4'd3);
    skip_to(50);
    full_line(-1);
    n_cmp++;
    if (out_rgb[150] !== C3) begin
      n_err++; $display("FAIL boxchg_old_top(150,50): got %h want %h", out_rgb[150], C3);
    end
    skip_to(300);
    hl = 12'd100; hr = 12'd300; vl = 12'd250; vr = 12'd400;
    full_line(-1);
    n_cmp++;
    if (out_rgb[100] !== pat(100, 300)) begin
      n_err++; $display("FAIL boxchg_midframe(100,300): got %h want %h", out_rgb[100], pat(100, 300));
    end
    new_frame(4'd3);
    skip_to(50);
    full_line(-1);
    n_cmp++;
    if (out_rgb[150] !== pat(150, 50)) begin
      n_err++; $display("FAIL boxchg_new_no_old(150,50): got %h want %h", out_rgb[150], pat(150, 50));
    end
    skip_to(300);
    full_line(-1);
    n_cmp++;
    if (out_rgb[100] !== C3) begin
      n_err++; $display("FAIL boxchg_new_left(100,300): got %h want %h", out_rgb[100], C3);
    end
    n_cmp++;
    if (out_rgb[150] !== pat(150, 300)) begin
      n_err++; $display("FAIL boxchg_new_inside(150,300): got %h want %h", out_rgb[150], pat(150, 300));
    end
  endtask

  task automatic test_degenerate();
    int bad;
    for (int b = 0; b < 2; b++) begin
      hl = (b == 0) ? 12'd200 : 12'd300;
      hr = (b == 0) ? 12'd200 : 12'd100;
      vl = 12'd10; vr = 12'd40;
      new_frame(4'd3);
      for (int k = 0; k < 2; k++) begin
        skip_to(10 + 10 * k);
        full_line(-1);
        bad = 0;
        for (int x = 0; x < W; x++) if (out_rgb[x] !== pat(x, cur_line - 1)) bad++;
        n_cmp++;
        if (bad !== 0) begin
          n_err++;
          $display("FAIL degenerate_box%0d_line%0d: %0d pixels modified, want 0", b, cur_line - 1, bad);
        end
      end
    end
  endtask

  task automatic test_en_off();
    int bad;
    hl = 12'd100; hr = 12'd300; vl = 12'd50; vr = 12'd200;
    for (int i = 0; i < 3; i++) new_frame(4'd2);
    n_cmp++;
    if ({lock_sort, locked} !== {4'd2, 1'b1}) begin
      n_err++; $display("FAIL lock_class2: lock_sort=%0d locked=%b want 2/1", lock_sort, locked);
    end
    en = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (vid.o_vsync !== 1'b0) begin
      n_err++; $display("FAIL vsync_not_early: o_vsync=%b want 0", vid.o_vsync);
    end
    @(posedge pixelclk);
    #1;
    n_cmp++;
    if (vid.o_vsync !== 1'b1) begin
      n_err++; $display("FAIL vsync_one_cycle: o_vsync=%b want 1", vid.o_vsync);
    end
    repeat (2) drive(24'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(24'h0, 1'b0, 1'b0, 1'b0);
    cur_line = 0;
    skip_to(50);
    full_line(-1);
    bad = 0;
    for (int x = 0; x < W; x++) if (out_rgb[x] !== pat(x, 50)) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL en_off_passthru_line50: %0d pixels differ from 1-cycle-delayed input, want 0", bad);
    end
    en = 1'b1;
    new_frame(4'd2);
    skip_to(50);
    full_line(-1);
    n_cmp++;
    if (out_rgb[150] !== C2) begin
      n_err++; $display("FAIL en_on_class2(150,50): got %h want %h", out_rgb[150], C2);
    end
  endtask

  task automatic test_reset_midline();
    logic [3:0] exp_lock [3] = '{4'd0, 4'd0, 4'd2};
    logic       exp_lkd  [3] = '{1'b0, 1'b0, 1'b1};
    new_frame(4'd2);
    skip_to(50);
    full_line(150);
    n_cmp++;
    if (out_rgb[100] !== C2) begin
      n_err++; $display("FAIL pre_reset_draw(100,50): got %h want %h", out_rgb[100], C2);
    end
    n_cmp++;
    if (out_rgb[200] !== pat(200, 50)) begin
      n_err++; $display("FAIL post_reset_nodraw(200,50): got %h want %h", out_rgb[200], pat(200, 50));
    end
    for (int i = 0; i < 3; i++) begin
      new_frame(4'd2);
      n_cmp++;
      if ({lock_sort, locked} !== {exp_lock[i], exp_lkd[i]}) begin
        n_err++;
        $display("FAIL relock_after_reset_frame%0d: lock_sort=%0d locked=%b want %0d/%b",
                 i + 1, lock_sort, locked, exp_lock[i], exp_lkd[i]);
      end
    end
    skip_to(50);
    full_line(-1);
    n_cmp++;
    if (out_rgb[200] !== C2) begin
      n_err++; $display("FAIL relocked_draw(200,50): got %h want %h", out_rgb[200], C2);
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_border();
    test_box_change();
    test_degenerate();
    test_en_off();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
